// File: rtl/segre_pkg.sv
// segre_pkg: shared dcache geometry parameters and refill FSM state type
package segre_pkg;
  localparam int ADDR_WIDTH         = 32;
  localparam int DCACHE_LANE_SIZE   = 128;
  localparam int DCACHE_NUM_LANES   = 4;
  localparam int DCACHE_INDEX_SIZE  = $clog2(DCACHE_NUM_LANES);
  localparam int DCACHE_LINE_OFFSET = $clog2(DCACHE_LANE_SIZE / 8);
  localparam int DCACHE_TAG_SIZE    = ADDR_WIDTH - DCACHE_LINE_OFFSET;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} refill_state_t;
endpackage

// File: rtl/segre_dcache_victim_sel.sv
// segre_dcache_victim_sel: round-robin victim lane pointer
module segre_dcache_victim_sel
  import segre_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         advance,
  input  logic                         clear,
  output logic [DCACHE_INDEX_SIZE-1:0] index
);
  // clear beats advance; the counter wraps naturally at the lane count
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) index <= '0;
    else if (clear) index <= '0;
    else if (advance) index <= index + 1'b1;
endmodule

// File: rtl/segre_dcache_refill.sv
// segre_dcache_refill: dcache miss handler fetching one line and filling a victim lane
module segre_dcache_refill
  import segre_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         miss_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [DCACHE_TAG_SIZE-1:0]   tag_i,
  input  logic                         invalidate_i,
  output logic                         mem_req_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [DCACHE_LANE_SIZE-1:0]  mem_data_i,
  output logic                         fill_o,
  output logic [DCACHE_INDEX_SIZE-1:0] fill_index_o,
  output logic [DCACHE_TAG_SIZE-1:0]   fill_tag_o,
  output logic [DCACHE_LANE_SIZE-1:0]  fill_data_o,
  output logic                         busy_o,
  output logic                         done_o
);
  refill_state_t               state;
  logic                        kill, fill_q, go_fill;
  logic [DCACHE_TAG_SIZE-1:0]  tag_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DCACHE_LANE_SIZE-1:0] data_q;

  assign go_fill      = mem_rvalid_i && ((state == REQ && mem_gnt_i) || state == WAIT);
  assign fill_o       = fill_q && !invalidate_i;
  assign busy_o       = state != IDLE;
  assign mem_addr_o   = addr_q;
  assign fill_tag_o   = tag_q;
  assign fill_data_o  = data_q;

  segre_dcache_victim_sel u_victim (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .advance (fill_o),
    .clear   (state == IDLE && invalidate_i),
    .index   (fill_index_o)
  );

  // refill sequencer; fill/done strobes are loaded on FILL entry and self-clear
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      state     <= IDLE;
      kill      <= 1'b0;
      fill_q    <= 1'b0;
      done_o    <= 1'b0;
      mem_req_o <= 1'b0;
      tag_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      fill_q <= 1'b0;
      done_o <= 1'b0;
      if (go_fill) begin
        data_q <= mem_data_i;
        fill_q <= !(kill || invalidate_i);
        done_o <= 1'b1;
      end
      case (state)
        IDLE: if (miss_i && !invalidate_i) begin
          tag_q     <= tag_i;
          addr_q    <= {addr_i[ADDR_WIDTH-1:DCACHE_LINE_OFFSET], {DCACHE_LINE_OFFSET{1'b0}}};
          mem_req_o <= 1'b1;
          state     <= REQ;
        end
        REQ: begin
          if (invalidate_i) kill <= 1'b1;
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= mem_rvalid_i ? FILL : WAIT;
          end
        end
        WAIT: begin
          if (invalidate_i) kill <= 1'b1;
          if (mem_rvalid_i) state <= FILL;
        end
        FILL: begin
          kill  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_segre_dcache_refill.sv
// tb_segre_dcache_refill: directed refill scenarios with a fill scoreboard
module tb_segre_dcache_refill;
  import segre_pkg::*;

  typedef struct {
    logic                         f;
    logic [DCACHE_INDEX_SIZE-1:0] idx;
    logic [DCACHE_TAG_SIZE-1:0]   tag;
    logic [DCACHE_LANE_SIZE-1:0]  data;
  } exp_t;

  logic                         clk_i = 0, rsn_i = 0, miss_i = 0, invalidate_i = 0;
  logic                         mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [ADDR_WIDTH-1:0]        addr_i = '0;
  logic [DCACHE_TAG_SIZE-1:0]   tag_i = '0;
  logic [DCACHE_LANE_SIZE-1:0]  mem_data_i = '0;
  logic                         mem_req_o, fill_o, busy_o, done_o;
  logic [ADDR_WIDTH-1:0]        mem_addr_o;
  logic [DCACHE_INDEX_SIZE-1:0] fill_index_o;
  logic [DCACHE_TAG_SIZE-1:0]   fill_tag_o;
  logic [DCACHE_LANE_SIZE-1:0]  fill_data_o;

  exp_t                         sb[$];
  int                           n_assert = 0, n_fail = 0;
  logic [DCACHE_INDEX_SIZE-1:0] mptr = '0;

  always #5 clk_i = ~clk_i;

  segre_dcache_refill dut (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .miss_i       (miss_i),
    .addr_i       (addr_i),
    .tag_i        (tag_i),
    .invalidate_i (invalidate_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_data_i   (mem_data_i),
    .fill_o       (fill_o),
    .fill_index_o (fill_index_o),
    .fill_tag_o   (fill_tag_o),
    .fill_data_o  (fill_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic chk(input string t, input logic [DCACHE_LANE_SIZE-1:0] o, input logic [DCACHE_LANE_SIZE-1:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet(input string t);
    chk({t, "_req"}, mem_req_o, 0);
    chk({t, "_fill"}, fill_o, 0);
    chk({t, "_done"}, done_o, 0);
    chk({t, "_busy"}, busy_o, 0);
  endtask

  task automatic all_zero(input string t);
    quiet(t);
    chk({t, "_addr"}, mem_addr_o, 0);
    chk({t, "_idx"}, fill_index_o, 0);
    chk({t, "_tag"}, fill_tag_o, 0);
    chk({t, "_data"}, fill_data_o, 0);
  endtask

  // gw: REQ cycles without grant; rw: WAIT cycles incl. the rvalid one (0 = gnt+rvalid together)
  // inv: 0 none, 1 invalidate in first WAIT cycle, 2 invalidate during FILL
  task automatic refill(input logic [ADDR_WIDTH-1:0] a, input logic [DCACHE_TAG_SIZE-1:0] tg,
                        input logic [DCACHE_LANE_SIZE-1:0] d, input int gw, input int rw, input int inv);
    exp_t                  e;
    logic [ADDR_WIDTH-1:0] ea;
    ea = a;
    ea[DCACHE_LINE_OFFSET-1:0] = '0;
    miss_i = 1; addr_i = a; tag_i = tg;
    sb.push_back('{inv == 0, mptr, tg, d});
    if (inv == 0) mptr++;
    tick;
    addr_i = ~a; tag_i = ~tg;
    chk("req_rise", mem_req_o, 1);
    chk("req_addr", mem_addr_o, ea);
    chk("busy_req", busy_o, 1);
    mem_rvalid_i = 1; mem_data_i = ~d;
    for (int i = 0; i < gw; i++) begin
      tick;
      chk("req_hold", mem_req_o, 1);
      chk("req_addr_hold", mem_addr_o, ea);
      chk("busy_req_hold", busy_o, 1);
    end
    mem_gnt_i = 1; mem_rvalid_i = (rw == 0); mem_data_i = d;
    tick;
    mem_gnt_i = 0; mem_rvalid_i = 0;
    if (rw > 0) begin
      chk("req_drop", mem_req_o, 0);
      chk("busy_wait", busy_o, 1);
      for (int i = 0; i < rw; i++) begin
        invalidate_i = (inv == 1 && i == 0);
        mem_rvalid_i = (i == rw - 1);
        tick;
        invalidate_i = 0; mem_rvalid_i = 0;
        if (i < rw - 1) chk("busy_wait_hold", busy_o, 1);
      end
    end
    if (inv == 2) begin
      invalidate_i = 1;
      #1;
    end
    chk("done_pulse", done_o, 1);
    chk("busy_fill", busy_o, 1);
    chk("sb_pending", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("fill", fill_o, e.f);
      chk("fill_index", fill_index_o, e.idx);
      chk("fill_tag", fill_tag_o, e.tag);
      chk("fill_data", fill_data_o, e.data);
    end
    miss_i = 0;
    tick;
    invalidate_i = 0;
    quiet("post");
  endtask

  initial begin
    #12;
    all_zero("reset");
    rsn_i = 1;
    tick;
    mem_rvalid_i = 1; mem_data_i = {4{32'hDEAD_BEEF}};
    tick;
    mem_rvalid_i = 0;
    all_zero("idle_rvalid");
    refill(32'h0000_1234, 28'h0000123, {16{8'hA5}}, 2, 3, 0);
    refill(32'h0000_5678, 28'h0000567, {4{32'h1111_2222}}, 0, 1, 0);
    refill(32'h8000_00FF, 28'h800000F, {4{32'h3333_4444}}, 1, 0, 0);
    refill(32'h0ABC_DEF1, 28'h0ABCDEF, {4{32'h5555_6666}}, 0, 2, 0);
    refill(32'hFFFF_FFFF, 28'hFFFFFFF, {4{32'h7777_8888}}, 0, 0, 0);
    refill(32'h1234_5678, 28'h1234567, {4{32'h9999_AAAA}}, 1, 2, 1);
    refill(32'h2222_0004, 28'h2222000, {4{32'hBBBB_CCCC}}, 0, 1, 0);
    refill(32'h3333_000C, 28'h3333000, {4{32'hDDDD_EEEE}}, 0, 1, 2);
    miss_i = 1; invalidate_i = 1; addr_i = 32'h4444_0000; tag_i = 28'h4444000;
    tick;
    miss_i = 0; invalidate_i = 0;
    quiet("miss_inv");
    tick;
    quiet("miss_inv_hold");
    mptr = '0;
    refill(32'h5555_0010, 28'h5555001, {4{32'h0F0F_F0F0}}, 0, 1, 0);
    miss_i = 1; addr_i = 32'h6666_0000; tag_i = 28'h6666000;
    tick;
    miss_i = 0; mem_gnt_i = 1;
    tick;
    mem_gnt_i = 0;
    chk("rst_wait_busy", busy_o, 1);
    chk("rst_wait_req", mem_req_o, 0);
    rsn_i = 0;
    #1;
    all_zero("rst_async");
    #3;
    rsn_i = 1;
    mem_rvalid_i = 1; mem_data_i = {4{32'hCAFE_F00D}};
    tick;
    mem_rvalid_i = 0;
    all_zero("late_rvalid");
    tick;
    all_zero("late_rvalid_hold");
    mptr = '0;
    refill(32'h7777_0020, 28'h7777002, {4{32'h1357_9BDF}}, 1, 1, 0);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/segre_dcache_refill.md
SEGRE_DCACHE_REFILL -- requirements
Module: segre_dcache_refill

Interface
REQ-001 SHALL take parameters from segre_pkg: DCACHE_TAG_SIZE, tag width; DCACHE_INDEX_SIZE, lane-index width (2); DCACHE_NUM_LANES, lane count (4); DCACHE_LANE_SIZE, line width in bits (128); ADDR_WIDTH, address width (32).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rsn_i  in  1  asynchronous active-low reset.
REQ-005 miss_i  in  1  tag lookup missed this cycle.
REQ-006 addr_i  in  ADDR_WIDTH  byte address of the missing access.
REQ-007 tag_i  in  DCACHE_TAG_SIZE  tag of the missing access.
REQ-008 invalidate_i  in  1  cache flush, same signal the tag array receives.
REQ-009 mem_req_o  out  1  line read request to memory.
REQ-010 mem_addr_o  out  ADDR_WIDTH  line-aligned request address.
REQ-011 mem_gnt_i  in  1  memory accepted request.
REQ-012 mem_rvalid_i  in  1  response line valid.
REQ-013 mem_data_i  in  DCACHE_LANE_SIZE  response line.
REQ-014 fill_o  out  1  one-cycle write strobe to tag and data arrays.
REQ-015 fill_index_o  out  DCACHE_INDEX_SIZE  victim lane.
REQ-016 fill_tag_o  out  DCACHE_TAG_SIZE  tag written to the victim lane.
REQ-017 fill_data_o  out  DCACHE_LANE_SIZE  line written to the victim lane.
REQ-018 busy_o  out  1  refill in progress; pipeline stalls.
REQ-019 done_o  out  1  one-cycle pulse; requester replays the access.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, FILL.
REQ-021 IDLE: miss_i=1 and invalidate_i=0 SHALL latch tag_i and addr_i with the low log2(DCACHE_LANE_SIZE/8) bits cleared, then move to REQ; miss_i in any other state SHALL be ignored.
REQ-022 REQ: mem_req_o=1 with stable mem_addr_o until mem_gnt_i; gnt only -> WAIT; gnt and mem_rvalid_i in the same cycle -> FILL with data captured.
REQ-023 WAIT: mem_rvalid_i=1 SHALL capture mem_data_i and move to FILL; otherwise WAIT persists indefinitely.
REQ-024 mem_rvalid_i in IDLE, or in REQ without gnt, SHALL be ignored.
REQ-025 FILL: for exactly one cycle, fill_o=1 and done_o=1, with registered index/tag/data; then -> IDLE.
REQ-026 Latency SHALL be: miss_i in cycle 0 -> mem_req_o in cycle 1; rvalid in cycle m -> fill_o and done_o in cycle m+1.
REQ-027 Victim pointer SHALL be a DCACHE_INDEX_SIZE-bit round-robin counter that drives fill_index_o and increments after each committed fill, wrapping 3->0.
REQ-028 busy_o SHALL equal (state != IDLE).
REQ-029 invalidate_i in REQ/WAIT SHALL set a kill flag; the memory transaction still completes.
REQ-030 With kill set, FILL SHALL hold fill_o=0, pulse done_o, and leave the pointer unchanged; kill clears on IDLE entry.
REQ-031 invalidate_i in IDLE SHALL reset the pointer to 0; simultaneous miss_i SHALL be dropped (invalidate wins).
REQ-032 invalidate_i in FILL SHALL suppress fill_o in that cycle.

Reset
REQ-033 Reset SHALL force, asynchronously: state IDLE, pointer 0, kill 0, all latched tag/address/data 0, and mem_req_o, fill_o, done_o, busy_o all 0.
REQ-034 Reset mid-transaction SHALL abandon it; after reset a late mem_rvalid_i SHALL be ignored.

Structure
REQ-035 The refill_state_t enum, ADDR_WIDTH and DCACHE_LINE_OFFSET SHALL live in segre_pkg.
REQ-036 The victim pointer SHALL be a sub-module segre_dcache_victim_sel (advance, clear, index out); everything else stays flat.

Verification
REQ-037 miss_i=1, addr_i=0x00001234, tag_i=0x0000123; gnt in cycle 3; rvalid in cycle 6 with data 0xA5.. -> mem_addr_o=0x00001230; fill_o and done_o in cycle 7; fill_index_o=0; busy_o high in cycles 1-6.
REQ-038 Five back-to-back misses -> fill_index_o sequence 0,1,2,3,0.
REQ-039 gnt and rvalid in the same cycle in REQ -> fill_o exactly one cycle later.
REQ-040 invalidate_i in WAIT -> done_o pulses, fill_o stays 0, next miss uses the same index.
REQ-041 miss_i and invalidate_i together in IDLE -> no mem_req_o, pointer=0; a second miss_i during WAIT is ignored.
REQ-042 rsn_i low in WAIT, then rvalid -> no fill_o or done_o; all outputs 0.
